memory_stage: RTL
=================

# memory_stage

Fourth pipeline stage and MEM/WB pipeline register. Takes the EX/MEM bundle, runs loads and stores against data memory over a req/ack handshake, and stalls upstream while an access is outstanding. Aligns and extends load data, then registers `mem_wb_regdest`, `mem_wb_writereg` and `mem_wb_wbvalue` for the writeback stage.

## Interface
- `ADDR_WIDTH`, default 32: width of `dmem_addr`, taken from the low bits of `ex_mem_aluresult`.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `ex_mem_valid`  in  1  EX/MEM slot holds an instruction.
- `ex_mem_regdest`  in  5  destination register.
- `ex_mem_writereg`  in  1  instruction writes a register.
- `ex_mem_aluresult`  in  32  ALU value, or the effective address for memory ops.
- `ex_mem_storevalue`  in  32  store data.
- `ex_mem_memread`  in  1  load.
- `ex_mem_memwrite`  in  1  store.
- `ex_mem_size`  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
- `ex_mem_signed`  in  1  sign-extend loads.
- `mem_stall`  out  1  upstream must hold EX/MEM inputs.
- `dmem_req`  out  1  access request.
- `dmem_we`  out  1  write.
- `dmem_addr`  out  ADDR_WIDTH  word-aligned address: low 2 bits are 0.
- `dmem_wdata`  out  32  write data, lane-replicated.
- `dmem_be`  out  4  byte enables.
- `dmem_ack`  in  1  access complete; `dmem_rdata` is valid in the same cycle.
- `dmem_rdata`  in  32  read word.
- `mem_misaligned`  out  1  one-cycle fault pulse.
- `mem_wb_regdest`  out  5  to writeback.
- `mem_wb_writereg`  out  1  to writeback.
- `mem_wb_wbvalue`  out  32  to writeback.

## Operation
- FSM has two states, IDLE and WAIT.
- **Memory op definition:** `ex_mem_valid` and (`memread` or `memwrite`). If both are set, the op is a store.
- **IDLE, non-memory op:** register `regdest`, `writereg` and `aluresult` into `mem_wb_*`.
- **IDLE, memory op:**
  - Register `dmem_*` and go to WAIT.
  - `mem_wb_writereg` loads 0 (bubble).
- **IDLE, `ex_mem_valid`=0:** `mem_wb_writereg` loads 0.
- **WAIT:**
  - `dmem_*` are held stable until `dmem_ack`=1 is sampled.
  - On ack: `dmem_req` and `dmem_we` clear and the state returns to IDLE.
  - On ack, `mem_wb_*` loads the extended read data for a load, or `aluresult` for a store.
  - While there is no ack, `mem_wb_writereg` is 0.
- **Store lanes:**
  - Byte: `be` = 1<<addr[1:0], `wdata` = byte ×4.
  - Half: `be` = addr[1] ? 1100 : 0011, `wdata` = half ×2.
  - Word: `be` = 1111.
- **Load:** select byte lane addr[1:0] or half lane addr[1], then zero- or sign-extend to 32 bits per `ex_mem_signed`.
- **`mem_stall`** (combinational) = `rst_n` & ((IDLE & memory op & not misaligned-faulted) | (WAIT & !`dmem_ack`)).
- `dmem_ack` in IDLE is ignored.

## Timing
- **Reset:** every registered output is 0, state is IDLE, and `mem_stall` is 0 while `rst_n`=0.
- **Reset during WAIT:** `dmem_req` is 0 after the edge and any late ack is ignored.
- **Non-memory latency:** 1 cycle, no stall.
- **Memory op accepted at cycle T:**
  - `dmem_req`=1 from T+1.
  - Ack at T+1+k (k≥0) gives `mem_wb_*` valid from T+2+k.
  - `mem_stall` is high from T through T+k and low in the ack cycle.
- The minimum load-to-writeback is 2 cycles; back-to-back memory ops are spaced at least 2 cycles apart.

## Configuration
- **`MEM_ALIGN_CHECK_EN` defined:** a half access with addr[0]=1, or a word access with addr[1:0]≠0, gets this behaviour:
  - No request is issued.
  - The op is not stalled.
  - `mem_misaligned` pulses for 1 cycle.
  - `mem_wb_writereg` loads 0.
- **Undefined:**
  - Offending low address bits are ignored: half uses addr[1], word uses lane 0.
  - `mem_misaligned` is tied to 0.

## Structure
- **Shared package `mem_defs`:** size encodings `MEM_SIZE_BYTE/HALF/WORD` and FSM state encodings `MEM_ST_IDLE/WAIT`.
- **Sub-module `load_extender`:** combinational; inputs are `rdata`, addr[1:0], size and signed; output is the 32-bit value.

## Test plan
- **Non-memory op:** `aluresult`=0x12345678, `regdest`=7, `writereg`=1 → next cycle `mem_wb_wbvalue`=0x12345678, `mem_wb_regdest`=7, no stall.
- **Load byte, signed:** addr 0x103, `rdata`=0x80FF_0000, ack at T+1 → `wbvalue`=0xFFFFFF80 at T+2, `dmem_addr`=0x100, stall only in T.
- **Store half:** addr 0x22, data 0x0000BEEF, ack delayed 3 cycles → `be`=1100, `wdata`=0xBEEFBEEF held 4 cycles, `mem_stall` high 4 cycles, `mem_wb_writereg`=0 throughout.
- **Reset in WAIT:** drop `rst_n` for 1 cycle, then ack → `dmem_req`=0, all `mem_wb_*`=0, and the ack has no effect.
- **Misaligned word load** at 0x101: with the macro, `mem_misaligned` is a 1-cycle pulse and no `dmem_req`; without it, the request goes to 0x100 and returns the full word.
- **Load-half unsigned** at 0x2, `rdata`=0x8001_1234 → `wbvalue`=0x00008001.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_defs : shared definitions for the memory pipeline stage.
//   - MEM_SIZE_* : access size encodings carried on ex_mem_size
//                  (2'b11 is handled as a word access)
//   - mem_state_t: handshake FSM states (MEM_ST_IDLE / MEM_ST_WAIT)
//   - helpers    : alignment test and store lane construction
// ---------------------------------------------------------------------------
package mem_defs;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

  typedef enum logic [0:0] {
    MEM_ST_IDLE = 1'b0,
    MEM_ST_WAIT = 1'b1
  } mem_state_t;

  // True when the low address bits do not fit the natural alignment of size.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      MEM_SIZE_BYTE: bad = 1'b0;
      MEM_SIZE_HALF: bad = lo[0];
      default:       bad = (lo != 2'b00);
    endcase
    return bad;
  endfunction

  // Byte enables for a store; offending low bits are ignored for half/word.
  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      MEM_SIZE_BYTE: be = 4'b0001 << lo;
      MEM_SIZE_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
      default:       be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated across every lane so the enables alone pick the target.
  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] w;
    case (size)
      MEM_SIZE_BYTE: w = {4{data[7:0]}};
      MEM_SIZE_HALF: w = {2{data[15:0]}};
      default:       w = data;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/memory_stage_load_extender.sv
// ---------------------------------------------------------------------------
// load_extender : picks the addressed byte/half lane out of a read word and
// zero- or sign-extends it to 32 bits. Purely combinational.
//   rdata    in  32  word returned by data memory
//   addr_lo  in   2  low address bits of the access
//   size     in   2  access size (mem_defs encodings)
//   sign_ext in   1  1 = sign-extend, 0 = zero-extend
//   value    out 32  aligned, extended load result
// ---------------------------------------------------------------------------
import mem_defs::*;

module load_extender (
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] value
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection; a half access only looks at addr_lo[1].
  always_comb begin
    byte_s = 8'h00;
    case (addr_lo)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      default: byte_s = rdata[31:24];
    endcase
    if (addr_lo[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // Extension to the full register width.
  always_comb begin
    value = 32'h0000_0000;
    case (size)
      MEM_SIZE_BYTE: value = {{24{sign_ext & byte_s[7]}}, byte_s};
      MEM_SIZE_HALF: value = {{16{sign_ext & half_s[15]}}, half_s};
      default:       value = rdata;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// ---------------------------------------------------------------------------
// memory_stage : fourth pipeline stage plus MEM/WB register.
// Issues loads/stores to data memory over a req/ack handshake, stalls the
// upstream stage while an access is outstanding and registers the writeback
// bundle (regdest, writereg, wbvalue).
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   ex_mem_*                EX/MEM bundle (valid, regdest, writereg, aluresult,
//                           storevalue, memread, memwrite, size, signed)
//   mem_stall               combinational hold request to upstream
//   dmem_req/we/addr/wdata/be, dmem_ack/rdata   data memory handshake
//   mem_misaligned          one-cycle alignment fault pulse
//   mem_wb_regdest/writereg/wbvalue             registered writeback bundle
//
// Build option: define MEM_ALIGN_CHECK_EN to fault misaligned half/word
// accesses instead of silently ignoring the offending address bits.
// ---------------------------------------------------------------------------
import mem_defs::*;

module memory_stage #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_mem_valid,
  input  logic [4:0]            ex_mem_regdest,
  input  logic                  ex_mem_writereg,
  input  logic [31:0]           ex_mem_aluresult,
  input  logic [31:0]           ex_mem_storevalue,
  input  logic                  ex_mem_memread,
  input  logic                  ex_mem_memwrite,
  input  logic [1:0]            ex_mem_size,
  input  logic                  ex_mem_signed,
  output logic                  mem_stall,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [31:0]           dmem_wdata,
  output logic [3:0]            dmem_be,
  input  logic                  dmem_ack,
  input  logic [31:0]           dmem_rdata,
  output logic                  mem_misaligned,
  output logic [4:0]            mem_wb_regdest,
  output logic                  mem_wb_writereg,
  output logic [31:0]           mem_wb_wbvalue
);

  mem_state_t            state_r, state_s;
  logic                  req_r, req_s;
  logic                  we_r, we_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_s;
  logic [31:0]           wdata_r, wdata_s;
  logic [3:0]            be_r, be_s;
  logic                  mis_r, mis_s;
  logic [4:0]            wb_regdest_r, wb_regdest_s;
  logic                  wb_writereg_r, wb_writereg_s;
  logic [31:0]           wb_value_r, wb_value_s;

  // Context of the outstanding access, needed when the ack arrives.
  logic                  pend_load_r, pend_load_s;
  logic [1:0]            pend_size_r, pend_size_s;
  logic                  pend_sign_r, pend_sign_s;
  logic [1:0]            pend_lo_r, pend_lo_s;
  logic [4:0]            pend_regdest_r, pend_regdest_s;
  logic                  pend_writereg_r, pend_writereg_s;
  logic [31:0]           pend_alu_r, pend_alu_s;

  logic                  mem_op_s;
  logic                  misalign_s;
  logic [31:0]           load_value_s;

  // Memory op decode and optional alignment fault detection.
  always_comb begin
    mem_op_s = ex_mem_valid & (ex_mem_memread | ex_mem_memwrite);
`ifdef MEM_ALIGN_CHECK_EN
    misalign_s = mem_op_s & is_misaligned(ex_mem_size, ex_mem_aluresult[1:0]);
`else
    misalign_s = 1'b0;
`endif
  end

  // Extension works from the latched context since ex_mem_* may move on.
  load_extender u_load_extender (
    .rdata    (dmem_rdata),
    .addr_lo  (pend_lo_r),
    .size     (pend_size_r),
    .sign_ext (pend_sign_r),
    .value    (load_value_s)
  );

  // Next-state logic of the handshake FSM.
  always_comb begin
    state_s = state_r;
    case (state_r)
      MEM_ST_IDLE: begin
        if (mem_op_s && !misalign_s) begin
          state_s = MEM_ST_WAIT;
        end else begin
          state_s = MEM_ST_IDLE;
        end
      end
      MEM_ST_WAIT: begin
        if (dmem_ack) begin
          state_s = MEM_ST_IDLE;
        end else begin
          state_s = MEM_ST_WAIT;
        end
      end
      default: state_s = MEM_ST_IDLE;
    endcase
  end

  // Next values of the request, writeback and pending-context registers.
  always_comb begin
    req_s           = req_r;
    we_s            = we_r;
    addr_s          = addr_r;
    wdata_s         = wdata_r;
    be_s            = be_r;
    mis_s           = 1'b0;
    wb_regdest_s    = wb_regdest_r;
    wb_writereg_s   = 1'b0;      // bubble unless something completes
    wb_value_s      = wb_value_r;
    pend_load_s     = pend_load_r;
    pend_size_s     = pend_size_r;
    pend_sign_s     = pend_sign_r;
    pend_lo_s       = pend_lo_r;
    pend_regdest_s  = pend_regdest_r;
    pend_writereg_s = pend_writereg_r;
    pend_alu_s      = pend_alu_r;
    case (state_r)
      MEM_ST_IDLE: begin
        if (mem_op_s) begin
          if (misalign_s) begin
            mis_s = 1'b1;
          end else begin
            // Store wins when both memread and memwrite are set.
            req_s           = 1'b1;
            we_s            = ex_mem_memwrite;
            addr_s          = {ex_mem_aluresult[ADDR_WIDTH-1:2], 2'b00};
            wdata_s         = store_wdata(ex_mem_size, ex_mem_storevalue);
            be_s            = store_be(ex_mem_size, ex_mem_aluresult[1:0]);
            pend_load_s     = ~ex_mem_memwrite;
            pend_size_s     = ex_mem_size;
            pend_sign_s     = ex_mem_signed;
            pend_lo_s       = ex_mem_aluresult[1:0];
            pend_regdest_s  = ex_mem_regdest;
            pend_writereg_s = ex_mem_writereg;
            pend_alu_s      = ex_mem_aluresult;
          end
        end else if (ex_mem_valid) begin
          wb_regdest_s  = ex_mem_regdest;
          wb_writereg_s = ex_mem_writereg;
          wb_value_s    = ex_mem_aluresult;
        end else begin
          wb_writereg_s = 1'b0;
        end
      end
      MEM_ST_WAIT: begin
        if (dmem_ack) begin
          req_s         = 1'b0;
          we_s          = 1'b0;
          wb_regdest_s  = pend_regdest_r;
          wb_writereg_s = pend_writereg_r;
          if (pend_load_r) begin
            wb_value_s = load_value_s;
          end else begin
            wb_value_s = pend_alu_r;
          end
        end else begin
          wb_writereg_s = 1'b0;
        end
      end
      default: begin
        req_s = 1'b0;
        we_s  = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= MEM_ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Output and context registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_r           <= 1'b0;
      we_r            <= 1'b0;
      addr_r          <= '0;
      wdata_r         <= 32'h0000_0000;
      be_r            <= 4'b0000;
      mis_r           <= 1'b0;
      wb_regdest_r    <= 5'd0;
      wb_writereg_r   <= 1'b0;
      wb_value_r      <= 32'h0000_0000;
      pend_load_r     <= 1'b0;
      pend_size_r     <= 2'b00;
      pend_sign_r     <= 1'b0;
      pend_lo_r       <= 2'b00;
      pend_regdest_r  <= 5'd0;
      pend_writereg_r <= 1'b0;
      pend_alu_r      <= 32'h0000_0000;
    end else begin
      req_r           <= req_s;
      we_r            <= we_s;
      addr_r          <= addr_s;
      wdata_r         <= wdata_s;
      be_r            <= be_s;
      mis_r           <= mis_s;
      wb_regdest_r    <= wb_regdest_s;
      wb_writereg_r   <= wb_writereg_s;
      wb_value_r      <= wb_value_s;
      pend_load_r     <= pend_load_s;
      pend_size_r     <= pend_size_s;
      pend_sign_r     <= pend_sign_s;
      pend_lo_r       <= pend_lo_s;
      pend_regdest_r  <= pend_regdest_s;
      pend_writereg_r <= pend_writereg_s;
      pend_alu_r      <= pend_alu_s;
    end
  end

  // Stall is combinational so upstream holds in the accept cycle itself;
  // it drops in the ack cycle so the next op can advance on that edge.
  assign mem_stall = rst_n &
                     (((state_r == MEM_ST_IDLE) & mem_op_s & ~misalign_s) |
                      ((state_r == MEM_ST_WAIT) & ~dmem_ack));

  assign dmem_req        = req_r;
  assign dmem_we         = we_r;
  assign dmem_addr       = addr_r;
  assign dmem_wdata      = wdata_r;
  assign dmem_be         = be_r;
  assign mem_misaligned  = mis_r;
  assign mem_wb_regdest  = wb_regdest_r;
  assign mem_wb_writereg = wb_writereg_r;
  assign mem_wb_wbvalue  = wb_value_r;

endmodule
